pll_cen_gen: RTL and testbench
==============================

Name: pll_cen_gen

Overview:
- Parametrised fractional clock-enable generator, successor to the fixed two-output PLL wrapper.
- Runs from one PLL output clock (e.g. 48 MHz) and derives NUM_CH independent fractional-rate clock-enable pulses (e.g. a 3.579545 MHz sound CEN) from phase accumulators.
- Each channel's rate is runtime-reprogrammable with glitch-free update.
- Gates every enable on a debounced PLL lock.

Parameters:
- NUM_CH, 2, number of enable channels (1..8).
- ACC_W, 32, accumulator/increment width in bits (8..32).
- LOCK_DLY, 16, consecutive synchronised-lock cycles required before ready asserts (>=1).
- INC_INIT, {NUM_CH{32'h0}}, packed reset increments; channel i uses bits [i*ACC_W +: ACC_W].

Ports:
- refclk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  raw PLL lock; asynchronous to refclk.
- ch_en  in  NUM_CH  per-channel run enable.
- phase_sync  in  1  single-cycle pulse; zeroes all accumulators together.
- cfg_wr  in  1  single-cycle increment write strobe.
- cfg_ch  in  3  target channel of the write.
- cfg_inc  in  ACC_W  new increment value.
- cfg_pending  out  NUM_CH  a written increment is waiting to be applied.
- ready  out  1  lock debounced; enables are live.
- cen  out  NUM_CH  one-cycle clock-enable pulses.
- cdiv  out  NUM_CH  square wave; toggles on each cen, so it runs at half the cen rate.

Behaviour:
- Reset (rst_n low, async): acc=0; inc=INC_INIT; shadow=0; cfg_pending=0; ready=0; cen=0; cdiv=0; lock counter=0; synchroniser=0.
- Lock path:
  - pll_locked passes through a 2-flop synchroniser to lk.
  - Counter increments while lk=1 and saturates at LOCK_DLY; ready=1 when count==LOCK_DLY (registered).
  - lk=0 clears the counter; ready drops on the next edge.
  - Earliest ready: LOCK_DLY+2 edges after pll_locked rises.
- On any cycle with ready=0: all acc forced to 0, cen=0, cdiv held. Increments and pending writes are retained.
- Channel i active when ready & ch_en[i]. Per active cycle: {carry, acc} = acc + inc (ACC_W+1-bit sum, wrap modulo 2^ACC_W).
  - cen[i] is registered carry: high exactly one cycle, the edge after the overflowing add.
  - cdiv[i] toggles on the same edge cen[i] asserts.
- Channel i inactive (ch_en[i]=0, ready=1): acc holds its value; cen=0.
- Mean cen rate = f_refclk * inc / 2^ACC_W.
  - inc=0: never pulses.
  - cen cannot be high on consecutive cycles unless inc >= 2^(ACC_W-1). Any inc is legal.
- Config write:
  - cfg_wr with cfg_ch < NUM_CH loads shadow[cfg_ch] and sets cfg_pending[cfg_ch].
  - cfg_ch >= NUM_CH is ignored: no state changes.
  - A second write while pending overwrites the shadow; pending stays 1.
- Apply rule: shadow copies to inc and pending clears on the edge where the channel's add produces carry=1, so the new rate starts from the wrapped phase. The add on that cycle uses the old inc.
  - Channel inactive or ready=0: apply on the next edge after the write.
  - cfg_wr and apply on the same channel, same cycle: the new write wins; shadow = new value, pending stays 1, and the older shadow is applied.
- phase_sync: all acc load 0 on the next edge; that cycle produces no carry and no cen. cdiv is unaffected; phase_sync has no effect on cfg_pending.
  - Simultaneous with a write: the write is captured normally.
- Reset mid-operation: instant clear to the reset values, including discarding pending writes.

Test Plan:
- ACC_W=8, LOCK_DLY=4, INC_INIT ch0=0x40, ch_en=1; raise pll_locked at edge 0 -> ready rises at edge 6; ch0 cen then pulses every 4th cycle; cdiv0 has period 8.
- Rate change mid-run: ch0 inc=0x40; write cfg_inc=0x80 mid-period -> cfg_pending[0]=1 until the next ch0 cen; after that pulse, cen every 2 cycles; no short or double pulse.
- Fractional: ACC_W=8, inc=0x60 -> over 256 cycles exactly 96 cen pulses, spacing 2 or 3 cycles; inc=0 -> zero pulses.
- Lock loss: deassert pll_locked while running -> ready low 3 edges later; cen stays 0 and acc=0; relock -> first ch0 cen exactly 4 cycles after ready (inc=0x40).
- phase_sync with ch0 inc=0x40 and ch1 inc=0x20 at arbitrary phases -> ch0 cen 4 cycles and ch1 cen 8 cycles after the sync edge; their pulses coincide.
- Edge cases:
  - cfg_ch=5 with NUM_CH=2 -> no change.
  - Writes to a disabled channel -> applied next edge.
  - Async rst_n pulse mid-period -> all outputs 0 immediately; inc back to INC_INIT.

Source files
------------

// File: rtl/pll_cen_gen.sv
// Fractional clock-enable generator: NUM_CH phase accumulators gated by a debounced
// PLL lock, with shadowed increments that take effect on the phase wrap.
module pll_cen_gen #(
    parameter int                      NUM_CH   = 2,
    parameter int                      ACC_W    = 32,
    parameter int                      LOCK_DLY = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = '0
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              phase_sync,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              ready,
    output logic [NUM_CH-1:0] cen,
    output logic [NUM_CH-1:0] cdiv
);

    localparam int               CNT_W   = $clog2(LOCK_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_DLY);

    logic             sync_q;
    logic             lk;
    logic [CNT_W-1:0] lock_cnt;

    // Lock debounce: ready follows a saturated run of LOCK_DLY synchronised lock samples.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            lk       <= 1'b0;
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lk     <= sync_q;
            if (!lk)
                lock_cnt <= '0;
            else if (lock_cnt != CNT_MAX)
                lock_cnt <= lock_cnt + CNT_W'(1);
            ready <= (lock_cnt == CNT_MAX);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] shadow;
        logic             pend;
        logic             cen_q;
        logic             cdiv_q;
        logic             active;
        logic             hit;
        logic             carry;
        logic             apply;
        logic [ACC_W:0]   sum;

        // A parked or unlocked channel has no wrap to wait for, so it applies at once.
        always_comb begin
            active = ready & ch_en[i];
            hit    = cfg_wr & (cfg_ch == 3'(i));
            sum    = {1'b0, acc} + {1'b0, inc};
            carry  = active & ~phase_sync & sum[ACC_W];
            apply  = pend & (carry | ~active);
        end

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                acc    <= '0;
                inc    <= INC_INIT[i*ACC_W +: ACC_W];
                shadow <= '0;
                pend   <= 1'b0;
                cen_q  <= 1'b0;
                cdiv_q <= 1'b0;
            end else begin
                if (!ready || phase_sync)
                    acc <= '0;
                else if (active)
                    acc <= sum[ACC_W-1:0];
                cen_q <= carry;
                if (carry)
                    cdiv_q <= ~cdiv_q;
                if (apply)
                    inc <= shadow;
                // A fresh write beats a same-cycle apply so it is never lost.
                if (hit) begin
                    shadow <= cfg_inc;
                    pend   <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign cfg_pending[i] = pend;
        assign cen[i]         = cen_q;
        assign cdiv[i]        = cdiv_q;
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Bench for pll_cen_gen: vector table, directed lock/rate/sync/reset sequences and
// randomized traffic checked against an integer phase model every cycle.
module tb_pll_cen_gen;

    localparam int          NUM_CH   = 2;
    localparam int          ACC_W    = 8;
    localparam int          LOCK_DLY = 4;
    localparam int          MOD      = 1 << ACC_W;
    localparam logic [15:0] INC_INIT = 16'h2040;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic        pll_locked;
    logic [1:0]  ch_en;
    logic        phase_sync;
    logic        cfg_wr;
    logic [2:0]  cfg_ch;
    logic [7:0]  cfg_inc;
    logic [1:0]  cfg_pending;
    logic        ready;
    logic [1:0]  cen;
    logic [1:0]  cdiv;

    pll_cen_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_DLY(LOCK_DLY), .INC_INIT(INC_INIT)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .ch_en(ch_en),
        .phase_sync(phase_sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .cfg_pending(cfg_pending), .ready(ready), .cen(cen), .cdiv(cdiv)
    );

    always #5 refclk = ~refclk;

    int errors = 0;
    int checks = 0;

    // Reference: integer phase per channel, ready derived from raw lock sample history.
    int m_phase [NUM_CH];
    int m_inc   [NUM_CH];
    int m_shadow[NUM_CH];
    bit m_pend  [NUM_CH];
    bit m_cen   [NUM_CH];
    bit m_cdiv  [NUM_CH];
    bit m_rdy;
    bit m_hist  [LOCK_DLY+3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i]  = 0;
            m_inc[i]    = int'((INC_INIT >> (i*ACC_W))) & (MOD - 1);
            m_shadow[i] = 0;
            m_pend[i]   = 0;
            m_cen[i]    = 0;
            m_cdiv[i]   = 0;
        end
        m_rdy = 0;
        for (int k = 0; k < LOCK_DLY+3; k++) m_hist[k] = 0;
    endtask

    task automatic model_edge();
        bit new_rdy, act, carry, apl;
        for (int k = LOCK_DLY+2; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pll_locked;
        // ready after this edge needs LOCK_DLY consecutive lock samples taken 3..LOCK_DLY+2 edges ago
        new_rdy = 1;
        for (int k = 3; k <= LOCK_DLY+2; k++) new_rdy &= m_hist[k];
        for (int i = 0; i < NUM_CH; i++) begin
            act   = m_rdy && ch_en[i];
            carry = 0;
            if (!m_rdy || phase_sync) begin
                m_phase[i] = 0;
            end else if (act) begin
                m_phase[i] += m_inc[i];
                if (m_phase[i] >= MOD) begin
                    carry = 1;
                    m_phase[i] -= MOD;
                end
            end
            apl = m_pend[i] && (carry || !act);
            if (apl) m_inc[i] = m_shadow[i];
            if (cfg_wr && cfg_ch == 3'(i)) begin
                m_shadow[i] = int'(cfg_inc);
                m_pend[i]   = 1;
            end else if (apl) begin
                m_pend[i] = 0;
            end
            m_cen[i] = carry;
            if (carry) m_cdiv[i] = !m_cdiv[i];
        end
        m_rdy = new_rdy;
    endtask

    function automatic logic [6:0] model_vec();
        return {m_rdy, m_cen[1], m_cen[0], m_cdiv[1], m_cdiv[0], m_pend[1], m_pend[0]};
    endfunction

    task automatic tick();
        @(posedge refclk);
        if (rst_n) model_edge(); else model_reset();
        @(negedge refclk);
        chk("model", 32'({ready, cen, cdiv, cfg_pending}), 32'(model_vec()));
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] val);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = val;
        tick();
        cfg_wr  = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 30);
    endtask

    task automatic wait_cen0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cen[0] && n < 30);
    endtask

    task automatic wait_pend0_clear();
        int n = 0;
        while (cfg_pending[0] && n < 30) begin
            tick();
            n++;
        end
        chk("pending_clears", 32'(cfg_pending[0]), 32'd0);
    endtask

    typedef struct {
        logic       lock;
        logic [1:0] en;
        logic       wr;
        logic [2:0] ch;
        logic [7:0] inc;
        logic       rdy;
        logic [1:0] cen;
        logic [1:0] cdiv;
        logic [1:0] pend;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic wr_i, input logic [2:0] ch_i, input logic [7:0] inc_i,
                                input logic rdy_i, input logic [1:0] cen_i,
                                input logic [1:0] cdiv_i, input logic [1:0] pend_i);
        vec_t v;
        v.lock = 1'b1; v.en = 2'b01; v.wr = wr_i; v.ch = ch_i; v.inc = inc_i;
        v.rdy = rdy_i; v.cen = cen_i; v.cdiv = cdiv_i; v.pend = pend_i;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, cnt, bad, last, gap;
        logic [1:0] seen[9];

        // Lock at edge 0, ready at edge 6, ch0 (inc 0x40) pulses from edge 10; ch1 write
        // while parked, out-of-range write, then ch0 rate change to 0x80 mid-period.
        for (int r = 0; r < 6; r++) tbl[r] = mk(0, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00);
        tbl[6]  = mk(0, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00);
        tbl[7]  = mk(0, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00);
        tbl[8]  = mk(1, 1, 8'h10, 1, 2'b00, 2'b00, 2'b10);
        tbl[9]  = mk(0, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00);
        tbl[10] = mk(0, 0, 8'h00, 1, 2'b01, 2'b01, 2'b00);
        tbl[11] = mk(1, 5, 8'h33, 1, 2'b00, 2'b01, 2'b00);
        tbl[12] = mk(1, 0, 8'h80, 1, 2'b00, 2'b01, 2'b01);
        tbl[13] = mk(0, 0, 8'h00, 1, 2'b00, 2'b01, 2'b01);
        tbl[14] = mk(0, 0, 8'h00, 1, 2'b01, 2'b00, 2'b00);
        tbl[15] = mk(0, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00);
        tbl[16] = mk(0, 0, 8'h00, 1, 2'b01, 2'b01, 2'b00);
        tbl[17] = mk(0, 0, 8'h00, 1, 2'b00, 2'b01, 2'b00);
        tbl[18] = mk(0, 0, 8'h00, 1, 2'b01, 2'b00, 2'b00);
        tbl[19] = mk(0, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00);

        rst_n = 1'b0; pll_locked = 1'b0; ch_en = 2'b00; phase_sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = 3'd0; cfg_inc = 8'h00;
        model_reset();
        repeat (3) @(negedge refclk);
        chk("reset_outputs", 32'({ready, cen, cdiv, cfg_pending}), 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 20; r++) begin
            pll_locked = tbl[r].lock; ch_en = tbl[r].en;
            cfg_wr = tbl[r].wr; cfg_ch = tbl[r].ch; cfg_inc = tbl[r].inc;
            tick();
            chk($sformatf("tbl[%0d]", r), 32'({ready, cen, cdiv, cfg_pending}),
                32'({tbl[r].rdy, tbl[r].cen, tbl[r].cdiv, tbl[r].pend}));
        end
        cfg_wr = 1'b0;

        // Lock loss: ready low on the 4th edge after the drop, no pulses while unlocked.
        pll_locked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lockloss_ready[%0d]", k), 32'(ready), (k < 3) ? 32'd1 : 32'd0);
        end
        wr(0, 8'h40);
        chk("unlocked_wr_pending", 32'(cfg_pending), 32'd1);
        tick();
        chk("unlocked_wr_applied", 32'(cfg_pending), 32'd0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cen != 2'b00) cnt++;
        end
        chk("unlocked_no_cen", 32'(cnt), 32'd0);

        pll_locked = 1'b1;
        wait_ready(n);
        chk("relock_ready_edges", 32'(n), 32'd7);
        wait_cen0(n);
        chk("relock_first_cen", 32'(n), 32'd4);

        // Fractional rate 0x60/256: 96 pulses in any 256-cycle window, gaps of 2 or 3.
        wr(0, 8'h60);
        wait_pend0_clear();
        cnt = 0; bad = 0; last = 0;
        for (int t = 1; t <= 256; t++) begin
            tick();
            if (cen[0]) begin
                gap = t - last;
                if (gap < 2 || gap > 3) bad++;
                last = t;
                cnt++;
            end
        end
        chk("frac_count", 32'(cnt), 32'd96);
        chk("frac_spacing_bad", 32'(bad), 32'd0);

        wr(0, 8'h00);
        wait_pend0_clear();
        cnt = 0;
        for (int t = 0; t < 256; t++) begin
            tick();
            if (cen[0]) cnt++;
        end
        chk("zero_inc_count", 32'(cnt), 32'd0);

        // Parked channels take new increments on the next edge.
        ch_en = 2'b00;
        wr(0, 8'h40);
        chk("parked_wr_pending", 32'(cfg_pending), 32'd1);
        tick();
        chk("parked_wr_applied", 32'(cfg_pending), 32'd0);
        wr(1, 8'h20);
        tick();
        chk("parked_wr1_applied", 32'(cfg_pending), 32'd0);

        // phase_sync from arbitrary phases aligns ch0 (0x40) and ch1 (0x20).
        ch_en = 2'b11;
        repeat ($urandom_range(3, 20)) tick();
        phase_sync = 1'b1;
        tick();
        seen[0] = cen;
        phase_sync = 1'b0;
        for (int k = 1; k < 9; k++) begin
            tick();
            seen[k] = cen;
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("sync_cen[%0d]", k), 32'(seen[k]),
                (k == 4) ? 32'd1 : (k == 8) ? 32'd3 : 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 79) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                pll_locked = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) ch_en = 2'($urandom_range(0, 3));
            phase_sync = ($urandom_range(0, 29) == 0);
            cfg_wr     = ($urandom_range(0, 5) == 0);
            cfg_ch     = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1))
                                                     : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       cfg_inc = 8'h00;
                1:       cfg_inc = 8'h80 | 8'($urandom_range(0, 255));
                default: cfg_inc = 8'($urandom_range(0, 255));
            endcase
            tick();
        end
        phase_sync = 1'b0; cfg_wr = 1'b0;

        // Async reset mid-period discards pending writes and restores INC_INIT.
        pll_locked = 1'b1; ch_en = 2'b01;
        wait_ready(n);
        repeat (5) tick();
        wr(0, 8'hF0);
        chk("pre_reset_pending", 32'(cfg_pending[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_outputs", 32'({ready, cen, cdiv, cfg_pending}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("post_reset_ready_edges", 32'(n), 32'd7);
        wait_cen0(n);
        chk("post_reset_first_cen", 32'(n), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
